// File: rtl/fifo_burst_reader.sv
// Drains start_count words from a Fifo1 dequeue port, then offers sum/count via result RDY/ENA; deq__ENA is combinational in READ.
// Result ready 1 cycle after last take; waits on deq__RDY indefinitely. Optional `FIFO_BURST_READER_STALL_EN adds result_stalls.
module fifo_burst_reader #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start__ENA,
  input  logic [CNT_W-1:0] start_count,
  output logic             start__RDY,
  input  logic             abort__ENA,
  input  logic             deq__RDY,
  input  logic [WIDTH-1:0] first,
  output logic             deq__ENA,
  output logic             result__RDY,
  input  logic             result__ENA,
  output logic [WIDTH-1:0] result_sum,
  output logic [CNT_W-1:0] result_words,
  output logic             result_aborted
`ifdef FIFO_BURST_READER_STALL_EN
  ,
  output logic [CNT_W-1:0] result_stalls
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] words;
  logic [CNT_W-1:0] remaining;
  logic             aborted;
  logic             take;
  logic             last_take;

  assign take      = (state == ST_READ) && deq__RDY;
  assign last_take = take && (remaining == CNT_W'(1));

  assign deq__ENA       = take;
  assign start__RDY     = (state == ST_IDLE);
  assign result__RDY    = (state == ST_DONE);
  assign result_sum     = sum;
  assign result_words   = words;
  assign result_aborted = aborted;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      sum       <= '0;
      words     <= '0;
      remaining <= '0;
      aborted   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start__ENA) begin
            sum       <= '0;
            words     <= '0;
            aborted   <= 1'b0;
            remaining <= start_count;
            state     <= (start_count == '0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (take) begin
            sum       <= sum + first;
            words     <= words + CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
          end
          // A coincident abort on the final word still counts as a full burst.
          if (last_take) begin
            aborted <= 1'b0;
            state   <= ST_DONE;
          end else if (abort__ENA) begin
            aborted <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (result__ENA) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_BURST_READER_STALL_EN
  logic [CNT_W-1:0] stalls;

  assign result_stalls = stalls;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stalls <= '0;
    end else if (state == ST_IDLE && start__ENA) begin
      stalls <= '0;
    end else if (state == ST_READ && !deq__RDY && stalls != '1) begin
      stalls <= stalls + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader; checks the optional stall counter when FIFO_BURST_READER_STALL_EN is defined.
module tb_fifo_burst_reader;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             start__ENA;
  logic [CNT_W-1:0] start_count;
  logic             start__RDY;
  logic             abort__ENA;
  logic             deq__RDY;
  logic [WIDTH-1:0] first;
  logic             deq__ENA;
  logic             result__RDY;
  logic             result__ENA;
  logic [WIDTH-1:0] result_sum;
  logic [CNT_W-1:0] result_words;
  logic             result_aborted;
`ifdef FIFO_BURST_READER_STALL_EN
  logic [CNT_W-1:0] result_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fifo_burst_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .start__ENA    (start__ENA),
    .start_count   (start_count),
    .start__RDY    (start__RDY),
    .abort__ENA    (abort__ENA),
    .deq__RDY      (deq__RDY),
    .first         (first),
    .deq__ENA      (deq__ENA),
    .result__RDY   (result__RDY),
    .result__ENA   (result__ENA),
    .result_sum    (result_sum),
    .result_words  (result_words),
    .result_aborted(result_aborted)
`ifdef FIFO_BURST_READER_STALL_EN
    ,
    .result_stalls (result_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_result(input string tag, input logic [WIDTH-1:0] s, input logic [CNT_W-1:0] w,
                            input logic ab);
    chk({tag, "_rdy"}, result__RDY, 1'b1);
    chk({tag, "_sum"}, result_sum, s);
    chk({tag, "_words"}, result_words, w);
    chk({tag, "_aborted"}, result_aborted, ab);
  endtask

  task automatic consume();
    result__ENA = 1'b1;
    tick();
    result__ENA = 1'b0;
  endtask

  task automatic start(input logic [CNT_W-1:0] n);
    start__ENA  = 1'b1;
    start_count = n;
    tick();
    start__ENA  = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; start__ENA = 1'b0; start_count = '0; abort__ENA = 1'b0;
    deq__RDY = 1'b0; first = '0; result__ENA = 1'b0;
    tick(); tick();
    #2;
    chk("rst_start_rdy", start__RDY, 1'b1);
    chk("rst_deq_ena", deq__ENA, 1'b0);
    chk("rst_result_rdy", result__RDY, 1'b0);
    chk("rst_sum", result_sum, '0);
    chk("rst_words", result_words, '0);
    chk("rst_aborted", result_aborted, 1'b0);
    nRST = 1'b1;
    tick();

    // Burst of 4 back-to-back words 1..4.
    deq__RDY = 1'b1; first = 32'd1;
    #2;
    chk("idle_no_deq", deq__ENA, 1'b0);
    start(16'd4);
    for (int i = 1; i <= 4; i++) begin
      first = WIDTH'(i);
      #2;
      chk($sformatf("b4_deq%0d", i), deq__ENA, 1'b1);
      tick();
    end
    #2;
    chk("b4_deq_after", deq__ENA, 1'b0);
    chk_result("b4", 32'd10, 16'd4, 1'b0);
    consume();
    #2;
    chk("b4_idle_rdy", start__RDY, 1'b1);
    chk("b4_idle_hold_sum", result_sum, 32'd10);

    // Zero-length burst.
    start(16'd0);
    #2;
    chk("z_no_deq", deq__ENA, 1'b0);
    chk_result("z", 32'd0, 16'd0, 1'b0);
    consume();

    // Wrapping sum with 2 stall cycles before word 2.
    deq__RDY = 1'b0;
    start(16'd3);
    deq__RDY = 1'b1; first = 32'hFFFF_FFFF;
    #2; chk("w_deq1", deq__ENA, 1'b1);
    tick();
    deq__RDY = 1'b0;
    #2; chk("w_stall1", deq__ENA, 1'b0);
    tick();
    #2; chk("w_stall2", deq__ENA, 1'b0);
    tick();
    deq__RDY = 1'b1; first = 32'h2;
    tick();
    first = 32'h5;
    tick();
    #2;
    chk_result("w", 32'h6, 16'd3, 1'b0);
`ifdef FIFO_BURST_READER_STALL_EN
    chk("w_stalls", result_stalls, 16'd2);
`endif
    consume();

    // Abort on 2nd take of a 5-word burst.
    start(16'd5);
    first = 32'd7;
    tick();
    first = 32'd8; abort__ENA = 1'b1;
    #2; chk("a_deq2", deq__ENA, 1'b1);
    tick();
    abort__ENA = 1'b0;
    #2;
    chk("a_no_deq", deq__ENA, 1'b0);
    chk_result("a", 32'd15, 16'd2, 1'b1);
    start__ENA = 1'b1; start_count = 16'd1;
    tick();
    start__ENA = 1'b0;
    #2;
    chk("a_done_ignores_start", result__RDY, 1'b1);
    chk("a_done_start_rdy", start__RDY, 1'b0);
    consume();

    // Abort coincident with the last word; start pulse in READ ignored.
    start(16'd2);
    first = 32'd3; start__ENA = 1'b1; start_count = 16'd0;
    #2; chk("c_read_start_rdy", start__RDY, 1'b0);
    tick();
    start__ENA = 1'b0;
    first = 32'd4; abort__ENA = 1'b1;
    #2; chk("c_deq2", deq__ENA, 1'b1);
    tick();
    abort__ENA = 1'b0;
    #2;
    chk_result("c", 32'd7, 16'd2, 1'b0);
    consume();
    #2;
    chk("c_idle_start_rdy", start__RDY, 1'b1);
    chk("c_idle_result_rdy", result__RDY, 1'b0);
    chk("c_idle_hold_words", result_words, 16'd2);

    // Reset mid-READ after one word.
    start(16'd3);
    first = 32'd9;
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #2;
    chk("r_start_rdy", start__RDY, 1'b1);
    chk("r_deq_ena", deq__ENA, 1'b0);
    chk("r_result_rdy", result__RDY, 1'b0);
    chk("r_sum", result_sum, '0);
    chk("r_words", result_words, '0);
    chk("r_aborted", result_aborted, 1'b0);
`ifdef FIFO_BURST_READER_STALL_EN
    chk("r_stalls", result_stalls, '0);
`endif
    tick();
    #2;
    chk("r_idle_no_deq", deq__ENA, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
